// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style 4-bit LCD write responder.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT0 = 3'd0,
        INIT1 = 3'd1,
        INIT2 = 3'd2,
        INIT3 = 3'd3,
        HI    = 3'd4,
        LO    = 3'd5
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_DISP   = 8'h08;
    localparam logic [7:0] CMD_FUNC   = 8'h20;
    localparam logic [7:0] CMD_ADDR   = 8'h80;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] LINE2_BASE = 8'h40;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    // Line 1 (0x00-0x0F) maps to 0-15, line 2 (0x40-0x4F) maps to 16-31.
    function automatic logic [ADDR_W-1:0] ddram_index(input logic [7:0] cmd);
        return {|(cmd & LINE2_BASE), cmd[3:0]};
    endfunction

endpackage

// File: rtl/lcd_nibble_rx_if.sv
// Pin-level LCD write bus plus the monitor-side outputs of lcd_nibble_rx.
interface lcd_nibble_rx_if;
    import lcd_pkg::*;

    // No valid/ready pair here: the LCD pins are a strobe-only protocol (data
    // sampled on the lcd_e falling edge), and byte_valid/proto_err are
    // single-cycle pulses with no backpressure; a consumer must take them as seen.
    logic                    lcd_e;
    logic                    lcd_sf_e;
    logic                    lcd_rs;
    logic                    lcd_rw;
    logic [3:0]              lcd_d;
    logic [ADDR_W-1:0]       rd_addr;

    logic                    byte_valid;
    logic                    byte_rs;
    logic [7:0]              byte_data;
    logic                    init_done;
    logic                    busy;
    logic                    disp_on;
    logic [ADDR_W-1:0]       cursor;
    logic                    proto_err;
    logic [7:0]              rd_char;
    lcd_state_e              state_dbg;

    modport master (
        output lcd_e, lcd_sf_e, lcd_rs, lcd_rw, lcd_d, rd_addr,
        input  byte_valid, byte_rs, byte_data, init_done, busy, disp_on,
               cursor, proto_err, rd_char, state_dbg
    );

    modport slave (
        input  lcd_e, lcd_sf_e, lcd_rs, lcd_rw, lcd_d, rd_addr,
        output byte_valid, byte_rs, byte_data, init_done, busy, disp_on,
               cursor, proto_err, rd_char, state_dbg
    );

endinterface

// File: rtl/lcd_ddram.sv
// 32x8 display buffer: one synchronous write port, one registered read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-cycle write to raddr_i shows up one read later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= BLANK_CHAR;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_nibble_rx.sv
// 4-bit LCD write responder: sync, init tracking, byte pairing, decode, buffer.
// Optional LCD_RX_E_FILTER_EN: reject lcd_e pulses shorter than MIN_E_HIGH cycles.
module lcd_nibble_rx
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    lcd_nibble_rx_if.slave bus
);

    if (SYNC_STAGES < 2 || MIN_E_HIGH < 1) begin : g_bad_param
        $error("lcd_nibble_rx: SYNC_STAGES must be >= 2 and MIN_E_HIGH >= 1");
    end

    // Sync vector layout: {sf_e, e, rw, rs, d[3:0]}.
    logic [7:0] sync_q [SYNC_STAGES];
    logic       e_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_dly_q <= 1'b0;
        end else begin
            sync_q[0] <= {bus.lcd_sf_e, bus.lcd_e, bus.lcd_rw, bus.lcd_rs, bus.lcd_d};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_dly_q <= sync_q[SYNC_STAGES-1][6];
        end
    end

    logic       s_sf, s_e, s_rw, s_rs;
    logic [3:0] s_d;
    logic       e_fall, access, strobe, e_short;

    assign {s_sf, s_e, s_rw, s_rs, s_d} = sync_q[SYNC_STAGES-1];
    assign e_fall = e_dly_q & ~s_e;
    assign access = s_sf & ~s_rw;

`ifdef LCD_RX_E_FILTER_EN
    localparam int HW = $clog2(MIN_E_HIGH + 1);
    logic [HW-1:0] hi_cnt_q;
    logic          e_long;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_q <= '0;
        end else if (!s_e) begin
            hi_cnt_q <= '0;
        end else if (hi_cnt_q != HW'(MIN_E_HIGH)) begin
            hi_cnt_q <= hi_cnt_q + 1'b1;
        end
    end

    assign e_long  = (hi_cnt_q == HW'(MIN_E_HIGH));
    assign strobe  = e_fall & access & e_long;
    assign e_short = e_fall & access & ~e_long;
`else
    assign strobe  = e_fall & access;
    assign e_short = 1'b0;
`endif

    lcd_state_e        state_q;
    logic [3:0]        hi_nib_q;
    logic              hi_rs_q;
    logic              byte_valid_q, byte_rs_q, proto_err_q;
    logic [7:0]        byte_data_q;
    logic              init_done_q, disp_on_q, id_q;
    logic              busy_q, clr_start_q;
    logic [ADDR_W-1:0] clr_cnt_q, cursor_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        lo_byte;

    assign lo_byte = {hi_nib_q, s_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT0;
            hi_nib_q     <= '0;
            hi_rs_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= '0;
            proto_err_q  <= 1'b0;
            init_done_q  <= 1'b0;
            disp_on_q    <= 1'b0;
            id_q         <= 1'b1;
            busy_q       <= 1'b0;
            clr_start_q  <= 1'b1;
            clr_cnt_q    <= '0;
            cursor_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            proto_err_q  <= 1'b0;
            wr_en_q      <= 1'b0;

            // Clear sequencer: the buffer is blanked once after reset release.
            if (busy_q) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) busy_q <= 1'b0;
            end else if (clr_start_q) begin
                clr_start_q <= 1'b0;
                busy_q      <= 1'b1;
                clr_cnt_q   <= '0;
            end

            if (e_short) begin
                proto_err_q <= 1'b1;
            end else if (strobe) begin
                if (busy_q || clr_start_q) begin
                    proto_err_q <= 1'b1;
                end else begin
                    case (state_q)
                        INIT0, INIT1, INIT2: begin
                            if (!s_rs && s_d == 4'h3) begin
                                state_q <= (state_q == INIT0) ? INIT1 :
                                           (state_q == INIT1) ? INIT2 : INIT3;
                            end else begin
                                proto_err_q <= 1'b1;
                                state_q     <= INIT0;
                            end
                        end
                        INIT3: begin
                            if (!s_rs && s_d == 4'h2) begin
                                init_done_q <= 1'b1;
                                state_q     <= HI;
                            end else if (s_rs || s_d != 4'h3) begin
                                proto_err_q <= 1'b1;
                                state_q     <= INIT0;
                            end
                        end
                        HI: begin
                            hi_nib_q <= s_d;
                            hi_rs_q  <= s_rs;
                            state_q  <= LO;
                        end
                        LO: begin
                            state_q <= HI;
                            if (s_rs != hi_rs_q) begin
                                proto_err_q <= 1'b1;
                            end else begin
                                byte_valid_q <= 1'b1;
                                byte_rs_q    <= s_rs;
                                byte_data_q  <= lo_byte;
                                if (s_rs) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= cursor_q;
                                    wr_data_q <= lo_byte;
                                    cursor_q  <= id_q ? cursor_q + 1'b1 : cursor_q - 1'b1;
                                end else if (lo_byte >= CMD_ADDR) begin
                                    cursor_q <= ddram_index(lo_byte);
                                end else if (lo_byte >= CMD_FUNC) begin
                                    cursor_q <= cursor_q;
                                end else if (lo_byte >= CMD_DISP) begin
                                    disp_on_q <= lo_byte[2];
                                end else if (lo_byte >= CMD_ENTRY) begin
                                    id_q <= lo_byte[1];
                                end else if (lo_byte >= CMD_HOME) begin
                                    cursor_q <= '0;
                                end else if (lo_byte == CMD_CLEAR) begin
                                    busy_q    <= 1'b1;
                                    clr_cnt_q <= '0;
                                    cursor_q  <= '0;
                                    id_q      <= 1'b1;
                                end
                            end
                        end
                        default: state_q <= INIT0;
                    endcase
                end
            end
        end
    end

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    assign mem_we    = busy_q | wr_en_q;
    assign mem_waddr = busy_q ? clr_cnt_q : wr_addr_q;
    assign mem_wdata = busy_q ? BLANK_CHAR : wr_data_q;

    lcd_ddram u_ddram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (bus.rd_addr),
        .rdata_o (bus.rd_char)
    );

    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_rs    = byte_rs_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.init_done  = init_done_q;
    assign bus.busy       = busy_q;
    assign bus.disp_on    = disp_on_q;
    assign bus.cursor     = cursor_q;
    assign bus.proto_err  = proto_err_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Bench for lcd_nibble_rx: vector table, corner sequences and random bytes vs a model.
module tb_lcd_nibble_rx;
    import lcd_pkg::*;

    localparam int SYNC   = 2;
    localparam int E_HIGH = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lcd_nibble_rx_if bus();

    lcd_nibble_rx #(.SYNC_STAGES(SYNC), .MIN_E_HIGH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int proto_cnt = 0;
    int bv_cnt = 0;
    int busy_run = 0;
    int last_busy_run = 0;

    logic [8:0] exp_q[$];
    logic [7:0] m_buf [32];
    int         m_cur;
    bit         m_id;
    bit         m_disp;

    typedef struct {
        bit         rs;
        logic [7:0] b;
        int         cur;
        bit         disp;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: byte stream scoreboard, pulse counters, busy run length.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.proto_err) proto_cnt++;
            if (bus.byte_valid) begin
                bv_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte_unexpected: got rs=%0d data=0x%0h expected none", bus.byte_rs, bus.byte_data);
                end else begin
                    check("byte_stream", {bus.byte_rs, bus.byte_data}, exp_q.pop_front());
                end
            end
        end
        if (bus.busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_cur = 0;
        m_id = 1;
        m_disp = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input bit rs, input logic [7:0] b);
        int v;
        int a;
        v = int'(b);
        exp_q.push_back({rs, b});
        if (rs) begin
            m_buf[m_cur] = b;
            m_cur = m_id ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
        end else if (v >= 128) begin
            a = v - 128;
            m_cur = (a >= 64 ? 16 : 0) + a % 16;
        end else if (v >= 32) begin
            m_cur = m_cur;
        end else if (v >= 8) begin
            m_disp = ((v >> 2) & 1) != 0;
        end else if (v >= 4) begin
            m_id = ((v >> 1) & 1) != 0;
        end else if (v >= 2) begin
            m_cur = 0;
        end else if (v == 1) begin
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            m_cur = 0;
            m_id = 1;
        end
    endtask

    task automatic drive_nibble(input bit rs, input logic [3:0] d, input int high);
        @(negedge clk);
        bus.lcd_sf_e = 1'b1;
        bus.lcd_rw   = 1'b0;
        bus.lcd_rs   = rs;
        bus.lcd_d    = d;
        @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (high) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b);
        model_byte(rs, b);
        drive_nibble(rs, b[7:4], E_HIGH);
        drive_nibble(rs, b[3:0], E_HIGH);
    endtask

    task automatic do_init();
        drive_nibble(1'b0, 4'h3, E_HIGH);
        drive_nibble(1'b0, 4'h3, E_HIGH);
        drive_nibble(1'b0, 4'h3, E_HIGH);
        drive_nibble(1'b0, 4'h2, E_HIGH);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
        end
        @(negedge clk);
    endtask

    task automatic read_buf(input int addr, output int val);
        bus.rd_addr = 5'(addr);
        @(negedge clk);
        val = int'(bus.rd_char);
    endtask

    task automatic do_reset();
        bus.lcd_e    = 1'b0;
        bus.lcd_sf_e = 1'b0;
        bus.lcd_rs   = 1'b0;
        bus.lcd_rw   = 1'b0;
        bus.lcd_d    = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, bvs, v, n;
        bit rs;
        logic [7:0] b;

        vecs[0] = '{1'b0, 8'h28, 0, 1'b0};
        vecs[1] = '{1'b0, 8'h06, 0, 1'b0};
        vecs[2] = '{1'b0, 8'h0C, 0, 1'b1};
        vecs[3] = '{1'b1, 8'h33, 1, 1'b1};
        vecs[4] = '{1'b1, 8'h35, 2, 1'b1};
        vecs[5] = '{1'b0, 8'hC0, 16, 1'b1};
        vecs[6] = '{1'b1, 8'h41, 17, 1'b1};
        vecs[7] = '{1'b0, 8'h04, 17, 1'b1};
        vecs[8] = '{1'b0, 8'h80, 0, 1'b1};
        vecs[9] = '{1'b1, 8'h58, 31, 1'b1};

        bus.lcd_e = 1'b0; bus.lcd_sf_e = 1'b0; bus.lcd_rs = 1'b0;
        bus.lcd_rw = 1'b0; bus.lcd_d = 4'h0; bus.rd_addr = 5'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.byte_valid, bus.byte_rs, bus.byte_data, bus.init_done,
                              bus.busy, bus.disp_on, bus.cursor, bus.proto_err}, 0);
        check("rst_rd_char", bus.rd_char, 8'h20);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("reset_clear_busy_len", last_busy_run, 32);
        check("reset_busy_done", bus.busy, 0);

        // Clean init sequence.
        p = proto_cnt;
        do_init();
        check("init_done", bus.init_done, 1);
        check("init_no_proto", proto_cnt - p, 0);
        read_buf(0, v);  check("init_blank_0", v, 8'h20);
        read_buf(13, v); check("init_blank_13", v, 8'h20);
        read_buf(31, v); check("init_blank_31", v, 8'h20);

        // Vector table.
        bvs = bv_cnt;
        for (int i = 0; i < 10; i++) begin
            send_byte(vecs[i].rs, vecs[i].b);
            check("vec_cursor", bus.cursor, vecs[i].cur);
            check("vec_disp", bus.disp_on, vecs[i].disp);
        end
        check("vec_byte_count", bv_cnt - bvs, 10);
        read_buf(0, v);  check("vec_buf0", v, 8'h58);
        read_buf(1, v);  check("vec_buf1", v, 8'h35);
        read_buf(16, v); check("vec_buf16", v, 8'h41);

        // Latency from pin-level fall of the low-nibble lcd_e to byte_valid.
        model_byte(1'b1, 8'h7A);
        drive_nibble(1'b1, 4'h7, E_HIGH);
        @(negedge clk);
        bus.lcd_rs = 1'b1;
        bus.lcd_d  = 4'hA;
        @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (E_HIGH) @(negedge clk);
        bus.lcd_e = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.byte_valid) break;
        end
        check("byte_latency", n, SYNC + 1);
        repeat (3) @(negedge clk);
        check("dec_cursor", bus.cursor, 30);
        read_buf(31, v); check("dec_buf31", v, 8'h7A);

        // Clear, then a strobe landing inside the busy window.
        p = proto_cnt;
        send_byte(1'b0, 8'h01);
        drive_nibble(1'b1, 4'h5, E_HIGH);
        wait_idle();
        check("clear_busy_len", last_busy_run, 32);
        check("clear_busy_proto", proto_cnt - p, 1);
        check("clear_cursor", bus.cursor, 0);
        for (int i = 0; i < 32; i++) begin
            read_buf(i, v);
            check("clear_blank", v, 8'h20);
        end
        send_byte(1'b1, 8'h42);
        check("post_clear_cursor", bus.cursor, 1);
        read_buf(0, v); check("post_clear_buf0", v, 8'h42);

        // HI/LO pair with mismatched rs.
        p = proto_cnt;
        bvs = bv_cnt;
        drive_nibble(1'b0, 4'h4, E_HIGH);
        drive_nibble(1'b1, 4'h1, E_HIGH);
        check("rs_mismatch_proto", proto_cnt - p, 1);
        check("rs_mismatch_no_byte", bv_cnt - bvs, 0);
        send_byte(1'b1, 8'h43);
        check("rs_mismatch_recover", bus.cursor, 2);

`ifdef LCD_RX_E_FILTER_EN
        p = proto_cnt;
        drive_nibble(1'b1, 4'h6, 2);
        check("short_e_proto", proto_cnt - p, 1);
        send_byte(1'b1, 8'h44);
        check("short_e_recover", bus.cursor, 3);
`else
        p = proto_cnt;
        model_byte(1'b1, 8'h66);
        drive_nibble(1'b1, 4'h6, 2);
        drive_nibble(1'b1, 4'h6, 2);
        check("short_e_accepted", proto_cnt - p, 0);
        check("short_e_cursor", bus.cursor, 3);
`endif

        // Protocol errors before init.
        do_reset();
        p = proto_cnt;
        drive_nibble(1'b0, 4'h3, E_HIGH);
        drive_nibble(1'b0, 4'h2, E_HIGH);
        check("preinit_bad_nibble", proto_cnt - p, 1);
        drive_nibble(1'b1, 4'h3, E_HIGH);
        check("preinit_rs1", proto_cnt - p, 2);
        check("preinit_not_done", bus.init_done, 0);
        do_init();
        check("reinit_done", bus.init_done, 1);
        check("reinit_no_proto", proto_cnt - p, 2);

        // Reset with a half-received byte.
        drive_nibble(1'b1, 4'hA, E_HIGH);
        do_reset();
        check("midbyte_rst_init", bus.init_done, 0);
        do_init();
        send_byte(1'b1, 8'h21);
        read_buf(0, v); check("midbyte_rst_buf0", v, 8'h21);

        // Random bytes against the model.
        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom_range(0, 1));
            b  = 8'($urandom_range(0, 255));
            send_byte(rs, b);
            wait_idle();
            check("rand_cursor", bus.cursor, m_cur);
        end
        check("rand_disp", bus.disp_on, m_disp);
        for (int i = 0; i < 32; i++) begin
            read_buf(i, v);
            check("rand_buf", v, m_buf[i]);
        end
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
